// File: rtl/ctl_trigger.sv
// ctl_trigger: turns the raw gun trigger into a clean, rate-limited shot event.
//
// A 2-FF synchronizer and a stable-count debouncer clean up trigger_raw; a
// rising edge of the debounced trigger either fires a shot or produces a dry
// fire, depending on no_ammo.  After a shot the block cools down and then
// waits for the trigger to be released, so a held trigger fires only once.
//
// Ports:
//   clk           system clock
//   rst           asynchronous reset, active low
//   reset_score   synchronous game restart, active high
//   trigger_raw   asynchronous gun trigger, 1 = pressed
//   no_ammo       magazine empty flag from ammo control
//   aim_x, aim_y  current crosshair position
//   shot_fired    one-cycle shot pulse to ammo control
//   dry_fire      one-cycle pulse for a press with an empty magazine
//   shot_x/shot_y crosshair position captured at the last shot
//   muzzle_flash  high for FLASH_CYCLES after each shot
//   ready         high while the FSM is in READY
//
// FSM states:
//   state          | meaning
//   ---------------+--------------------------------------------------
//   S_READY        | armed, waiting for a debounced press
//   S_FIRE         | shot issued this cycle, loads the cooldown timer
//   S_COOLDOWN     | counting down the re-arm gap, presses ignored
//   S_WAIT_RELEASE | waiting for the debounced trigger to go low

module ctl_trigger #(
    parameter int unsigned DEBOUNCE_CYCLES = 650000,
    parameter int unsigned COOLDOWN_CYCLES = 16250000,
    parameter int unsigned FLASH_CYCLES    = 3250000,
    parameter int unsigned POS_W           = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reset_score,
    input  logic             trigger_raw,
    input  logic             no_ammo,
    input  logic [POS_W-1:0] aim_x,
    input  logic [POS_W-1:0] aim_y,
    output logic             shot_fired,
    output logic             dry_fire,
    output logic [POS_W-1:0] shot_x,
    output logic [POS_W-1:0] shot_y,
    output logic             muzzle_flash,
    output logic             ready
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned CD_W = $clog2(COOLDOWN_CYCLES + 1);
    localparam int unsigned FL_W = $clog2(FLASH_CYCLES + 1);

    // The debounce count is compared against its last value before the
    // increment, so the flip happens on the edge where it would reach the limit.
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CD_W-1:0] COOL_LOAD  = CD_W'(COOLDOWN_CYCLES - 1);
    localparam logic [FL_W-1:0] FLASH_LOAD = FL_W'(FLASH_CYCLES);

    typedef enum logic [1:0] {
        S_READY,
        S_FIRE,
        S_COOLDOWN,
        S_WAIT_RELEASE
    } state_t;

    logic [1:0]      sync_q;
    logic            trig_s;
    logic            trig_db;
    logic            trig_db_q;
    logic [DB_W-1:0] db_cnt;
    logic            press;

    state_t          state;
    state_t          state_nxt;
    logic [CD_W-1:0] cool_cnt;
    logic [CD_W-1:0] cool_nxt;
    logic [FL_W-1:0] flash_cnt;
    logic [FL_W-1:0] flash_nxt;
    logic            shot_fired_nxt;
    logic            dry_fire_nxt;
    logic [POS_W-1:0] shot_x_nxt;
    logic [POS_W-1:0] shot_y_nxt;

    // Synchronizer and debouncer are deliberately not cleared by reset_score,
    // so a restart does not lose track of a trigger that is already held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], trigger_raw};
        end
    end

    assign trig_s = sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt    <= '0;
            trig_db   <= 1'b0;
            trig_db_q <= 1'b0;
        end else begin
            trig_db_q <= trig_db;
            if (trig_s == trig_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                trig_db <= trig_s;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign press = trig_db & ~trig_db_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_READY;
            cool_cnt   <= '0;
            flash_cnt  <= '0;
            shot_fired <= 1'b0;
            dry_fire   <= 1'b0;
            shot_x     <= '0;
            shot_y     <= '0;
        end else begin
            state      <= state_nxt;
            cool_cnt   <= cool_nxt;
            flash_cnt  <= flash_nxt;
            shot_fired <= shot_fired_nxt;
            dry_fire   <= dry_fire_nxt;
            shot_x     <= shot_x_nxt;
            shot_y     <= shot_y_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cool_nxt       = cool_cnt;
        // Flash timer runs down in every state and parks at zero.
        flash_nxt      = (flash_cnt != '0) ? flash_cnt - FL_W'(1) : '0;
        shot_fired_nxt = 1'b0;
        dry_fire_nxt   = 1'b0;
        shot_x_nxt     = shot_x;
        shot_y_nxt     = shot_y;

        if (reset_score) begin
            // Land in WAIT_RELEASE so a trigger held across the restart
            // has to be released before it can fire.
            state_nxt  = S_WAIT_RELEASE;
            cool_nxt   = '0;
            flash_nxt  = '0;
            shot_x_nxt = '0;
            shot_y_nxt = '0;
        end else begin
            case (state)
                S_READY: begin
                    if (press) begin
                        if (!no_ammo) begin
                            state_nxt      = S_FIRE;
                            shot_fired_nxt = 1'b1;
                            shot_x_nxt     = aim_x;
                            shot_y_nxt     = aim_y;
                            flash_nxt      = FLASH_LOAD;
                        end else begin
                            state_nxt    = S_WAIT_RELEASE;
                            dry_fire_nxt = 1'b1;
                        end
                    end
                end
                S_FIRE: begin
                    state_nxt = S_COOLDOWN;
                    cool_nxt  = COOL_LOAD;
                end
                S_COOLDOWN: begin
                    if (cool_cnt == '0) begin
                        state_nxt = S_WAIT_RELEASE;
                    end else begin
                        cool_nxt = cool_cnt - CD_W'(1);
                    end
                end
                S_WAIT_RELEASE: begin
                    if (!trig_db) begin
                        state_nxt = S_READY;
                    end
                end
                default: begin
                    state_nxt = S_READY;
                end
            endcase
        end
    end

    assign muzzle_flash = (flash_cnt != '0);
    assign ready        = (state == S_READY);

endmodule

// File: tb/tb_ctl_trigger.sv
// Bench for ctl_trigger with DEBOUNCE=4, COOLDOWN=10, FLASH=6.
// A table of press scenarios is applied in a loop, followed by hand-written
// sequences for latency, bounce, cooldown presses and both resets.  Every
// expected shot position is queued when the press is driven and checked by a
// monitor when shot_fired appears.

module tb_ctl_trigger;

    localparam int DB  = 4;
    localparam int CD  = 10;
    localparam int FL  = 6;
    localparam int PW  = 12;

    logic          clk;
    logic          rst;
    logic          reset_score;
    logic          trigger_raw;
    logic          no_ammo;
    logic [PW-1:0] aim_x;
    logic [PW-1:0] aim_y;
    logic          shot_fired;
    logic          dry_fire;
    logic [PW-1:0] shot_x;
    logic [PW-1:0] shot_y;
    logic          muzzle_flash;
    logic          ready;

    ctl_trigger #(
        .DEBOUNCE_CYCLES(DB),
        .COOLDOWN_CYCLES(CD),
        .FLASH_CYCLES   (FL),
        .POS_W          (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .reset_score (reset_score),
        .trigger_raw (trigger_raw),
        .no_ammo     (no_ammo),
        .aim_x       (aim_x),
        .aim_y       (aim_y),
        .shot_fired  (shot_fired),
        .dry_fire    (dry_fire),
        .shot_x      (shot_x),
        .shot_y      (shot_y),
        .muzzle_flash(muzzle_flash),
        .ready       (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [PW-1:0] x;
        logic [PW-1:0] y;
    } pos_t;

    pos_t sb_q[$];

    task automatic sb_push(input logic [PW-1:0] x, input logic [PW-1:0] y);
        pos_t p;
        p.x = x;
        p.y = y;
        sb_q.push_back(p);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    int   cyc       = 0;
    int   shot_cnt  = 0;
    int   dry_cnt   = 0;
    int   flash_cnt = 0;
    int   last_shot = 0;
    bit   have_last = 1'b0;
    logic prev_shot = 1'b0;
    logic prev_dry  = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_shot = 1'b0;
            prev_dry  = 1'b0;
        end else begin
            pos_t p;
            cyc++;
            if (shot_fired) begin
                shot_cnt++;
                check("shot_back_to_back", prev_shot, 0);
                if (have_last) check("shot_spacing_ge_12", (cyc - last_shot) >= CD + 2, 1);
                last_shot = cyc;
                have_last = 1'b1;
                check("sb_has_expected_shot", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    p = sb_q.pop_front();
                    check("sb_shot_x", shot_x, p.x);
                    check("sb_shot_y", shot_y, p.y);
                end
            end
            if (dry_fire) begin
                dry_cnt++;
                check("dry_back_to_back", prev_dry, 0);
                check("dry_without_shot", shot_fired, 0);
            end
            if (muzzle_flash) flash_cnt++;
            prev_shot = shot_fired;
            prev_dry  = dry_fire;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic          na;
        int            hold;
        logic [PW-1:0] x;
        logic [PW-1:0] y;
        int            exp_shots;
        int            exp_dry;
        logic [PW-1:0] exp_sx;
        logic [PW-1:0] exp_sy;
    } row_t;

    row_t rows[6];

    initial begin
        int s0, d0, f0;

        rows[0] = '{1'b0,   3, 12'd100,  12'd200,  0, 0, 12'd0,    12'd0};
        rows[1] = '{1'b0,   4, 12'd320,  12'd240,  1, 0, 12'd320,  12'd240};
        rows[2] = '{1'b1,  10, 12'd111,  12'd222,  0, 1, 12'd320,  12'd240};
        rows[3] = '{1'b0, 100, 12'd4095, 12'd0,    1, 0, 12'd4095, 12'd0};
        rows[4] = '{1'b1,   4, 12'd7,    12'd8,    0, 1, 12'd4095, 12'd0};
        rows[5] = '{1'b0,  30, 12'd0,    12'd4095, 1, 0, 12'd0,    12'd4095};

        rst         = 1'b1;
        reset_score = 1'b0;
        trigger_raw = 1'b0;
        no_ammo     = 1'b0;
        aim_x       = '0;
        aim_y       = '0;
        #2 rst = 1'b0;
        #1;
        check("rst_shot_fired", shot_fired, 0);
        check("rst_dry_fire", dry_fire, 0);
        check("rst_muzzle_flash", muzzle_flash, 0);
        check("rst_shot_x", shot_x, 0);
        check("rst_shot_y", shot_y, 0);
        check("rst_ready", ready, 1);
        tick(3);
        rst = 1'b1;
        tick(5);
        check("idle_ready", ready, 1);

        // Table-driven press scenarios.
        for (int i = 0; i < 6; i++) begin
            s0 = shot_cnt; d0 = dry_cnt; f0 = flash_cnt;
            aim_x   = rows[i].x;
            aim_y   = rows[i].y;
            no_ammo = rows[i].na;
            if (rows[i].exp_shots != 0) sb_push(rows[i].x, rows[i].y);
            trigger_raw = 1'b1;
            tick(rows[i].hold);
            trigger_raw = 1'b0;
            tick(60);
            check($sformatf("row%0d_shots", i), shot_cnt - s0, rows[i].exp_shots);
            check($sformatf("row%0d_dry", i), dry_cnt - d0, rows[i].exp_dry);
            check($sformatf("row%0d_flash_cycles", i), flash_cnt - f0, FL * rows[i].exp_shots);
            check($sformatf("row%0d_shot_x", i), shot_x, rows[i].exp_sx);
            check($sformatf("row%0d_shot_y", i), shot_y, rows[i].exp_sy);
            check($sformatf("row%0d_ready", i), ready, 1);
        end
        no_ammo = 1'b0;

        // Clean press latency and flash width, then a long hold and a re-press.
        s0 = shot_cnt;
        aim_x = 12'd320; aim_y = 12'd240;
        sb_push(12'd320, 12'd240);
        trigger_raw = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick(1);
            check($sformatf("lat_shot_e%0d", e), shot_fired, e == DB + 3);
            check($sformatf("lat_flash_e%0d", e), muzzle_flash, (e >= DB + 3) && (e < DB + 3 + FL));
            check($sformatf("lat_ready_e%0d", e), ready, e < DB + 3);
        end
        tick(86);
        check("hold_single_shot", shot_cnt - s0, 1);
        check("hold_not_ready", ready, 0);
        trigger_raw = 1'b0;
        tick(20);
        check("release_ready", ready, 1);
        aim_x = 12'd321; aim_y = 12'd241;
        sb_push(12'd321, 12'd241);
        trigger_raw = 1'b1;
        tick(12);
        check("repress_second_shot", shot_cnt - s0, 2);
        trigger_raw = 1'b0;
        tick(30);

        // Bounce: 3 high / 1 low, five times, then a steady press.
        s0 = shot_cnt;
        aim_x = 12'd50; aim_y = 12'd60;
        sb_push(12'd50, 12'd60);
        for (int b = 0; b < 5; b++) begin
            trigger_raw = 1'b1;
            tick(3);
            trigger_raw = 1'b0;
            tick(1);
        end
        check("bounce_no_shot", shot_cnt - s0, 0);
        trigger_raw = 1'b1;
        tick(30);
        check("bounce_one_shot", shot_cnt - s0, 1);
        trigger_raw = 1'b0;
        tick(40);
        check("bounce_ready", ready, 1);

        // Release and re-press that debounce inside the cooldown window.
        s0 = shot_cnt; d0 = dry_cnt;
        aim_x = 12'd70; aim_y = 12'd80;
        sb_push(12'd70, 12'd80);
        trigger_raw = 1'b1;
        tick(4);
        trigger_raw = 1'b0;
        tick(4);
        trigger_raw = 1'b1;
        tick(20);
        check("cool_press_shots", shot_cnt - s0, 1);
        check("cool_press_dry", dry_cnt - d0, 0);
        check("cool_press_wait", ready, 0);
        trigger_raw = 1'b0;
        tick(30);
        check("cool_after_shots", shot_cnt - s0, 1);
        check("cool_after_dry", dry_cnt - d0, 0);
        check("cool_after_ready", ready, 1);

        // reset_score while the trigger is held and the flash is running.
        s0 = shot_cnt;
        aim_x = 12'd90; aim_y = 12'd91;
        sb_push(12'd90, 12'd91);
        trigger_raw = 1'b1;
        tick(9);
        check("rs_flash_before", muzzle_flash, 1);
        reset_score = 1'b1;
        tick(1);
        reset_score = 1'b0;
        check("rs_flash_cleared", muzzle_flash, 0);
        check("rs_shot_x_cleared", shot_x, 0);
        check("rs_shot_y_cleared", shot_y, 0);
        check("rs_not_ready", ready, 0);
        tick(40);
        check("rs_held_no_shot", shot_cnt - s0, 1);
        trigger_raw = 1'b0;
        tick(20);
        check("rs_release_ready", ready, 1);
        aim_x = 12'd92; aim_y = 12'd93;
        sb_push(12'd92, 12'd93);
        trigger_raw = 1'b1;
        tick(12);
        check("rs_repress_shot", shot_cnt - s0, 2);
        trigger_raw = 1'b0;
        tick(30);

        // Asynchronous reset in the middle of the flash.
        s0 = shot_cnt;
        aim_x = 12'd10; aim_y = 12'd20;
        sb_push(12'd10, 12'd20);
        trigger_raw = 1'b1;
        tick(9);
        check("arst_flash_before", muzzle_flash, 1);
        check("arst_not_ready_before", ready, 0);
        #3;
        rst = 1'b0;
        trigger_raw = 1'b0;
        #1;
        check("arst_flash", muzzle_flash, 0);
        check("arst_ready", ready, 1);
        check("arst_shot_x", shot_x, 0);
        check("arst_shot_y", shot_y, 0);
        check("arst_shot_fired", shot_fired, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(40);
        check("arst_after_shots", shot_cnt - s0, 1);
        check("arst_after_ready", ready, 1);

        check("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
